// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified RAM data port between instruction fetch (IF)
// and load/store (LS). One access is granted per cycle. The RAM answers one
// cycle later, and that read word is routed back to whichever requester won.
// Misaligned or invalid-size LS accesses are granted but never reach the RAM.
// They are answered with ls_err instead.
// Optional feature: define ARB_STARVE_GUARD_EN to stop LS from starving IF.
// With it, IF is forced through after MAX_STARVE consecutive contended losses.
//
// Handshake: a requester holds *_req (and its address/data) until it sees
// *_gnt high in the same cycle. The response comes back as a single-cycle
// *_rvalid pulse in the next cycle. There is no backpressure on the response.
// *_rdata is 0 whenever *_rvalid is low.
module mem_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_SIZE  = 10,
  parameter int MAX_STARVE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [ADDR_SIZE-1:0] ls_addr,
  input  logic [WORD_SIZE-1:0] ls_wdata,
  input  logic [1:0]           ls_size,
  input  logic                 ls_unsigned,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [WORD_SIZE-1:0] ls_rdata,
  output logic                 ls_err,
  output logic                 mem_en_write,
  output logic                 mem_en_read,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_din,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  input  logic [WORD_SIZE-1:0] mem_dout
);

  // IDLE: no response owed this cycle. BUSY: the RAM word arriving now belongs to owner_ls_q.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;
  logic   owner_ls_q, owner_ls_d;  // 1: response goes to LS, 0: to IF
  logic   err_q, err_d;            // pending LS response is a rejection
  logic   store_q, store_d;        // pending LS response is a write acknowledge
  logic   ls_misaligned;
  logic   if_forced;               // IF overrides LS priority this cycle

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_STARVE + 1);
  logic [CW-1:0] starve_q;

  assign if_forced = if_req && (starve_q == CW'(MAX_STARVE));

  // Count the cycles IF loses to LS; an IF grant of any kind clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (if_gnt) begin
      starve_q <= '0;
    end else if (ls_gnt && if_req && (starve_q != CW'(MAX_STARVE))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign if_forced = 1'b0;
`endif

  // Reject half accesses on odd addresses, word accesses not on a 4-byte boundary, and size 11.
  always_comb begin
    ls_misaligned = 1'b0;
    case (ls_size)
      2'b01:   ls_misaligned = ls_addr[0];
      2'b10:   ls_misaligned = (ls_addr[1:0] != 2'b00);
      2'b11:   ls_misaligned = 1'b1;
      default: ls_misaligned = 1'b0;
    endcase
  end

  // Pick the winner, drive the RAM port, and decide the response owed next cycle.
  always_comb begin
    if_gnt       = 1'b0;
    ls_gnt       = 1'b0;
    mem_en_write = 1'b0;
    mem_en_read  = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    mem_size     = 2'b00;
    mem_unsigned = 1'b0;
    state_d      = IDLE;
    owner_ls_d   = owner_ls_q;
    err_d        = 1'b0;
    store_d      = 1'b0;
    if (!rst) begin
      if (ls_req && !if_forced) begin
        ls_gnt       = 1'b1;
        mem_en_write = ls_we && !ls_misaligned;
        mem_en_read  = !ls_we && !ls_misaligned;
        mem_addr     = ls_addr;
        mem_din      = ls_we ? ls_wdata : '0;
        mem_size     = ls_size;
        mem_unsigned = ls_unsigned;
        state_d      = BUSY;
        owner_ls_d   = 1'b1;
        err_d        = ls_misaligned;
        store_d      = ls_we;
      end else if (if_req) begin
        if_gnt       = 1'b1;
        mem_en_read  = 1'b1;
        mem_addr     = if_addr;
        mem_size     = 2'b10;
        mem_unsigned = 1'b1;
        state_d      = BUSY;
        owner_ls_d   = 1'b0;
      end
    end
  end

  // Remember who owns the response that the RAM returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      err_q      <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      err_q      <= err_d;
      store_q    <= store_d;
    end
  end

  // The return path passes mem_dout through to the owner only; stores and errors return 0.
  assign if_rvalid = (state_q == BUSY) && !owner_ls_q;
  assign ls_rvalid = (state_q == BUSY) && owner_ls_q;
  assign if_rdata  = if_rvalid ? mem_dout : '0;
  assign ls_err    = ls_rvalid && err_q;
  assign ls_rdata  = (ls_rvalid && !err_q && !store_q) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed traffic for mem_arbiter.
// A behavioural byte-array RAM serves the port. A separate byte-array
// reference predicts grants and responses. Define ARB_STARVE_GUARD_EN for
// both the bench and the design to exercise the starvation guard.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int A  = 10;
  localparam int MS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req, if_gnt, if_rvalid;
  logic [A-1:0] if_addr;
  logic [W-1:0] if_rdata;
  logic         ls_req, ls_we, ls_unsigned, ls_gnt, ls_rvalid, ls_err;
  logic [A-1:0] ls_addr;
  logic [W-1:0] ls_wdata, ls_rdata;
  logic [1:0]   ls_size;
  logic         mem_en_write, mem_en_read, mem_unsigned;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_din;
  logic [1:0]   mem_size;
  logic [W-1:0] mem_dout = '0;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t       if_q[$];
  exp_t       ls_q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         starve = 0;
  logic [7:0] ram_b [0:(1<<A)-1];
  logic [7:0] ref_b [0:(1<<A)-1];

  mem_arbiter #(.WORD_SIZE(W), .ADDR_SIZE(A), .MAX_STARVE(MS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en_write(mem_en_write), .mem_en_read(mem_en_read), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_dout(mem_dout)
  );

  // Clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected responses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Select and extend a byte/half/word from an aligned little-endian word.
  function automatic logic [W-1:0] extend(input logic [W-1:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[int'(off)*8 +: 8];
    h = word[int'(off[1])*16 +: 16];
    case (size)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic misaligned(input logic [A-1:0] a, input logic [1:0] size);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [W-1:0] ref_load(input logic [A-1:0] a, input logic [1:0] size,
                                            input logic uns);
    logic [A-1:0] base;
    base = {a[A-1:2], 2'b00};
    return extend({ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]}, a[1:0], size, uns);
  endfunction

  task automatic ref_store(input logic [A-1:0] a, input logic [1:0] size, input logic [W-1:0] d);
    logic [A-1:0] base;
    base = {a[A-1:2], 2'b00};
    if (size == 2'b00) ref_b[a] = d[int'(a[1:0])*8 +: 8];
    else if (size == 2'b01) begin
      ref_b[{a[A-1:1], 1'b0}]     = d[int'(a[1])*16 +: 8];
      ref_b[{a[A-1:1], 1'b0} + 1] = d[int'(a[1])*16 + 8 +: 8];
    end else for (int i = 0; i < 4; i++) ref_b[base + A'(i)] = d[i*8 +: 8];
  endtask

  // RAM model: writes lanes of mem_din, returns the extended word one cycle after a read enable
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1<<A); i++) ram_b[i] <= ref_b[i];
    end else if (mem_en_write) begin
      if (mem_size == 2'b00) ram_b[mem_addr] <= mem_din[int'(mem_addr[1:0])*8 +: 8];
      else if (mem_size == 2'b01) begin
        ram_b[{mem_addr[A-1:1], 1'b0}]     <= mem_din[int'(mem_addr[1])*16 +: 8];
        ram_b[{mem_addr[A-1:1], 1'b0} + 1] <= mem_din[int'(mem_addr[1])*16 + 8 +: 8];
      end else for (int i = 0; i < 4; i++) ram_b[{mem_addr[A-1:2], 2'b00} + A'(i)] <= mem_din[i*8 +: 8];
    end
    if (mem_en_read)
      mem_dout <= extend({ram_b[{mem_addr[A-1:2], 2'd3}], ram_b[{mem_addr[A-1:2], 2'd2}],
                          ram_b[{mem_addr[A-1:2], 2'd1}], ram_b[{mem_addr[A-1:2], 2'd0}]},
                         mem_addr[1:0], mem_size, mem_unsigned);
    else
      mem_dout <= $urandom;
  end

  // Monitor: pop an expectation whenever a response is presented, flag missing ones
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_if_ls", {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_err, ls_rdata}, '0);
      chk("rst_mem", {mem_en_write, mem_en_read, mem_addr, mem_din, mem_size, mem_unsigned}, '0);
    end else begin
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("if_spurious_rvalid", if_rvalid, 1'b0);
        else begin
          mon_e = if_q.pop_front();
          chk("if_rsp_cycle", cyc, mon_e.due);
          chk("if_rdata", if_rdata, mon_e.data);
        end
      end else begin
        chk("if_rdata_idle", if_rdata, '0);
        if (if_q.size() > 0 && if_q[0].due <= cyc) begin
          chk("if_missing_rvalid", if_rvalid, 1'b1);
          void'(if_q.pop_front());
        end
      end
      if (ls_rvalid) begin
        if (ls_q.size() == 0) chk("ls_spurious_rvalid", ls_rvalid, 1'b0);
        else begin
          mon_e = ls_q.pop_front();
          chk("ls_rsp_cycle", cyc, mon_e.due);
          chk("ls_err_rdata", {ls_err, ls_rdata}, {mon_e.err, mon_e.data});
        end
      end else begin
        chk("ls_idle", {ls_err, ls_rdata}, '0);
        if (ls_q.size() > 0 && ls_q[0].due <= cyc) begin
          chk("ls_missing_rvalid", ls_rvalid, 1'b1);
          void'(ls_q.pop_front());
        end
      end
    end
  end

  task automatic set_ls(input logic we, input logic [A-1:0] a, input logic [1:0] size,
                        input logic uns, input logic [W-1:0] d);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_size = size; ls_unsigned = uns; ls_wdata = d;
  endtask

  // One cycle: predict the winner, check the RAM port, queue the response, retire granted requests
  task automatic step();
    logic         exp_ls, exp_if, mis;
    logic [W-1:0] v;
    exp_t         e;
    @(negedge clk);
    exp_ls = ls_req;
    exp_if = if_req && !ls_req;
`ifdef ARB_STARVE_GUARD_EN
    if (ls_req && if_req && starve == MS) begin
      exp_ls = 1'b0;
      exp_if = 1'b1;
    end
`endif
    chk("grant", {if_gnt, ls_gnt}, {exp_if, exp_ls});
    if (exp_ls) begin
      mis = misaligned(ls_addr, ls_size);
      chk("ls_mem_en", {mem_en_write, mem_en_read}, mis ? 2'b00 : {ls_we, !ls_we});
      if (!mis) chk("ls_mem_port", {mem_addr, mem_size, mem_unsigned}, {ls_addr, ls_size, ls_unsigned});
      if (!mis && ls_we) chk("ls_mem_din", mem_din, ls_wdata);
      v = '0;
      if (!mis && ls_we) ref_store(ls_addr, ls_size, ls_wdata);
      else if (!mis) v = ref_load(ls_addr, ls_size, ls_unsigned);
      e.err = mis; e.data = v; e.due = cyc + 1;
      ls_q.push_back(e);
    end else if (exp_if) begin
      chk("if_mem_port", {mem_en_write, mem_en_read, mem_addr, mem_size, mem_unsigned},
          {1'b0, 1'b1, if_addr, 2'b10, 1'b1});
      e.err = 1'b0; e.data = ref_load(if_addr, 2'b10, 1'b1); e.due = cyc + 1;
      if_q.push_back(e);
    end else begin
      chk("idle_mem_en", {mem_en_write, mem_en_read}, 2'b00);
    end
    if (exp_if) starve = 0;
    else if (exp_ls && if_req) starve = (starve < MS) ? starve + 1 : MS;
    @(posedge clk);
    #1;
    if (exp_ls) ls_req = 1'b0;
    if (exp_if) if_req = 1'b0;
  endtask

  task automatic rand_reqs();
    int r;
    if (!if_req && $urandom_range(0, 99) < 60) begin
      if_req  = 1'b1;
      if_addr = A'($urandom_range(0, 15) * 4);
    end
    if (!ls_req && $urandom_range(0, 99) < 55) begin
      r = $urandom_range(0, 9);
      set_ls(1'($urandom_range(0, 1)), A'($urandom_range(0, 63)),
             (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
             1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 99) < 70) begin
        if (ls_size == 2'b01) ls_addr[0] = 1'b0;
        if (ls_size == 2'b10) ls_addr[1:0] = 2'b00;
      end
    end
  endtask

  // Stimulus: reset, directed scenarios, random traffic, drain, report
  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_size = 2'b00; ls_unsigned = 1'b0;
    for (int i = 0; i < (1<<A); i++) ref_b[i] = 8'($urandom);
    {ref_b[19], ref_b[18], ref_b[17], ref_b[16]} = 32'h0050_0093;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // lone fetch
    if_req = 1'b1; if_addr = 10'h010;
    repeat (3) step();
    // contention: LS load word first, IF right behind it
    set_ls(1'b0, 10'h020, 2'b10, 1'b0, '0);
    if_req = 1'b1; if_addr = 10'h024;
    repeat (3) step();
    // store byte then unsigned reload, store 0x80 then signed reload
    set_ls(1'b1, 10'h003, 2'b00, 1'b0, 32'hAB00_0000); step();
    set_ls(1'b0, 10'h003, 2'b00, 1'b1, '0); step();
    set_ls(1'b1, 10'h003, 2'b00, 1'b0, 32'h8000_0000); step();
    set_ls(1'b0, 10'h003, 2'b00, 1'b0, '0); step();
    // misaligned half, then invalid size
    set_ls(1'b0, 10'h001, 2'b01, 1'b0, '0); step();
    set_ls(1'b1, 10'h004, 2'b11, 1'b0, 32'h1234_5678); step();
    step();
    // both requesters held high
    for (int i = 0; i < 12; i++) begin
      if (!ls_req) set_ls(1'b0, A'($urandom_range(0, 15) * 4), 2'b10, 1'b0, '0);
      if (!if_req) begin if_req = 1'b1; if_addr = A'($urandom_range(0, 15) * 4); end
      step();
    end
    ls_req = 1'b0; if_req = 1'b0;
    repeat (2) step();
    // reset in the cycle after a load grant
    set_ls(1'b0, 10'h020, 2'b10, 1'b0, '0); step();
    rst = 1'b1;
    if_q.delete(); ls_q.delete(); starve = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step();
    // random traffic
    repeat (400) begin
      rand_reqs();
      step();
    end
    ls_req = 1'b0; if_req = 1'b0;
    repeat (3) step();
    chk("queues_drained", if_q.size() + ls_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
